// File: rtl/divisor_segmentado_param.sv
// Parametrised pipelined integer divider (restoring, one quotient bit per stage).
// Accepts one signed or unsigned division per cycle and returns quotient,
// remainder, tag and divide-by-zero / overflow flags SIZE+2 cycles later.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. The whole
// pipeline advances together only when the output register is empty or being
// consumed (advance = !out_valid || out_ready), so in_ready equals advance and
// everything, bubbles included, holds still while the consumer stalls.
module divisor_segmentado_param #(
  parameter int SIZE  = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [SIZE-1:0]  in_num,
  input  logic [SIZE-1:0]  in_den,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  out_coc,
  output logic [SIZE-1:0]  out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dbz,
  output logic             out_ovf
);

  localparam logic [SIZE-1:0] MIN_VAL = {1'b1, {(SIZE-1){1'b0}}};

  logic advance;

  // Stage 0 holds the captured operation; stages 1..SIZE each hold the state
  // after one more restoring step. st_quo starts as |num| and shifts quotient
  // bits in from the right while the dividend bits shift out on the left.
  logic             st_valid [0:SIZE];
  logic [TAG_W-1:0] st_tag   [0:SIZE];
  logic             st_negq  [0:SIZE];
  logic             st_negr  [0:SIZE];
  logic             st_dbz   [0:SIZE];
  logic             st_ovf   [0:SIZE];
  logic [SIZE-1:0]  st_num   [0:SIZE];
  logic [SIZE-1:0]  st_rem   [0:SIZE];
  logic [SIZE-1:0]  st_quo   [0:SIZE];
  logic [SIZE-1:0]  st_den   [0:SIZE-1];

  logic [SIZE:0]    shifted  [1:SIZE];
  logic [SIZE:0]    trial    [1:SIZE];
  logic [SIZE-1:0]  nxt_rem  [1:SIZE];
  logic [SIZE-1:0]  nxt_quo  [1:SIZE];

  logic             num_neg;
  logic             den_neg;
  logic [SIZE-1:0]  num_mag;
  logic [SIZE-1:0]  den_mag;
  logic [SIZE-1:0]  fin_coc;
  logic [SIZE-1:0]  fin_res;

  // Global stall: the output register is the only place backpressure lands.
  always_comb begin
    advance  = !out_valid || out_ready;
    in_ready = advance;
  end

  // Operand magnitudes and signs for the capture stage.
  always_comb begin
    num_neg = in_signed && in_num[SIZE-1];
    den_neg = in_signed && in_den[SIZE-1];
    num_mag = num_neg ? -in_num : in_num;
    den_mag = den_neg ? -in_den : in_den;
  end

  // One restoring step per stage on a (SIZE+1)-bit partial remainder. The
  // remainder stays below the divisor, so a clear borrow bit means "subtract".
  always_comb begin
    for (int i = 1; i <= SIZE; i++) begin
      shifted[i] = {st_rem[i-1], st_quo[i-1][SIZE-1]};
      trial[i]   = shifted[i] - {1'b0, st_den[i-1]};
      if (!trial[i][SIZE]) begin
        nxt_rem[i] = trial[i][SIZE-1:0];
        nxt_quo[i] = {st_quo[i-1][SIZE-2:0], 1'b1};
      end else begin
        nxt_rem[i] = shifted[i][SIZE-1:0];
        nxt_quo[i] = {st_quo[i-1][SIZE-2:0], 1'b0};
      end
    end
  end

  // Sign correction and flag overrides feeding the output register.
  always_comb begin
    fin_coc = st_negq[SIZE] ? -st_quo[SIZE] : st_quo[SIZE];
    fin_res = st_negr[SIZE] ? -st_rem[SIZE] : st_rem[SIZE];
    if (st_dbz[SIZE]) begin
      fin_coc = '1;
      fin_res = st_num[SIZE];
    end else if (st_ovf[SIZE]) begin
      fin_coc = MIN_VAL;
      fin_res = '0;
    end
  end

  // Pipeline registers: capture, SIZE division steps, output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= SIZE; i++) begin
        st_valid[i] <= 1'b0;
        st_tag[i]   <= '0;
        st_negq[i]  <= 1'b0;
        st_negr[i]  <= 1'b0;
        st_dbz[i]   <= 1'b0;
        st_ovf[i]   <= 1'b0;
        st_num[i]   <= '0;
        st_rem[i]   <= '0;
        st_quo[i]   <= '0;
      end
      for (int i = 0; i < SIZE; i++) begin
        st_den[i] <= '0;
      end
      out_valid <= 1'b0;
      out_coc   <= '0;
      out_res   <= '0;
      out_tag   <= '0;
      out_dbz   <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (advance) begin
      st_valid[0] <= in_valid;
      st_tag[0]   <= in_tag;
      st_negq[0]  <= num_neg ^ den_neg;
      st_negr[0]  <= num_neg;
      st_dbz[0]   <= (in_den == '0);
      st_ovf[0]   <= in_signed && (in_num == MIN_VAL) && (in_den == '1);
      st_num[0]   <= in_num;
      st_rem[0]   <= '0;
      st_quo[0]   <= num_mag;
      st_den[0]   <= den_mag;
      for (int i = 1; i <= SIZE; i++) begin
        st_valid[i] <= st_valid[i-1];
        st_tag[i]   <= st_tag[i-1];
        st_negq[i]  <= st_negq[i-1];
        st_negr[i]  <= st_negr[i-1];
        st_dbz[i]   <= st_dbz[i-1];
        st_ovf[i]   <= st_ovf[i-1];
        st_num[i]   <= st_num[i-1];
        st_rem[i]   <= nxt_rem[i];
        st_quo[i]   <= nxt_quo[i];
      end
      for (int i = 1; i < SIZE; i++) begin
        st_den[i] <= st_den[i-1];
      end
      out_valid <= st_valid[SIZE];
      out_coc   <= fin_coc;
      out_res   <= fin_res;
      out_tag   <= st_tag[SIZE];
      out_dbz   <= st_dbz[SIZE];
      out_ovf   <= st_ovf[SIZE];
    end
  end

endmodule

// File: tb/tb_divisor_segmentado_param.sv
// Bench for divisor_segmentado_param: an 8-bit/4-bit-tag instance for directed,
// backpressure and reset cases, and a 16-bit/1-bit-tag instance for a random sweep.
// Expected results come from a plain-arithmetic reference and flow through
// per-instance queues that the output monitors pop on every consumed result.
module tb_divisor_segmentado_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- 8-bit instance ----------------
  logic       in8_valid = 1'b0, in8_ready, in8_signed = 1'b0;
  logic [7:0] in8_num = '0, in8_den = '0;
  logic [3:0] in8_tag = '0;
  logic       out8_valid, out8_ready = 1'b1;
  logic [7:0] out8_coc, out8_res;
  logic [3:0] out8_tag;
  logic       out8_dbz, out8_ovf;

  divisor_segmentado_param #(.SIZE(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in8_valid), .in_ready(in8_ready), .in_signed(in8_signed),
    .in_num(in8_num), .in_den(in8_den), .in_tag(in8_tag),
    .out_valid(out8_valid), .out_ready(out8_ready),
    .out_coc(out8_coc), .out_res(out8_res), .out_tag(out8_tag),
    .out_dbz(out8_dbz), .out_ovf(out8_ovf)
  );

  // ---------------- 16-bit instance ----------------
  logic        in16_valid = 1'b0, in16_ready, in16_signed = 1'b0;
  logic [15:0] in16_num = '0, in16_den = '0;
  logic [0:0]  in16_tag = '0;
  logic        out16_valid, out16_ready = 1'b1;
  logic [15:0] out16_coc, out16_res;
  logic [0:0]  out16_tag;
  logic        out16_dbz, out16_ovf;

  divisor_segmentado_param #(.SIZE(16), .TAG_W(1)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in16_valid), .in_ready(in16_ready), .in_signed(in16_signed),
    .in_num(in16_num), .in_den(in16_den), .in_tag(in16_tag),
    .out_valid(out16_valid), .out_ready(out16_ready),
    .out_coc(out16_coc), .out_res(out16_res), .out_tag(out16_tag),
    .out_dbz(out16_dbz), .out_ovf(out16_ovf)
  );

  // ---------------- scoreboard state ----------------
  logic [21:0] exp8_q[$];
  int          acc8_q[$];
  int          stl8_q[$];
  logic [34:0] exp16_q[$];
  int          acc16_q[$];
  int          stall8 = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: signed values reinterpreted as integers, divided with the
  // language's truncating / and %, then the special cases applied on top.
  // Packed as {tag, dbz, ovf, coc, res}.
  function automatic logic [63:0] ref_pack(input int w, input bit sgn,
      input longint unsigned n_u, input longint unsigned d_u, input longint unsigned tag);
    longint    mask, n, d, coc, res;
    bit        dbz, ovf;
    logic [63:0] r;
    mask = (longint'(1) << w) - 1;
    n = longint'(n_u);
    d = longint'(d_u);
    if (sgn && n_u >= (longint'(1) << (w - 1))) n = n - (longint'(1) << w);
    if (sgn && d_u >= (longint'(1) << (w - 1))) d = d - (longint'(1) << w);
    dbz = (d == 0);
    ovf = 1'b0;
    if (dbz) begin
      coc = mask;
      res = longint'(n_u);
    end else if (sgn && n == -(longint'(1) << (w - 1)) && d == -1) begin
      ovf = 1'b1;
      coc = n & mask;
      res = 0;
    end else begin
      coc = (n / d) & mask;
      res = (n % d) & mask;
    end
    r = 64'(tag);
    r = (r << 1) | 64'(dbz);
    r = (r << 1) | 64'(ovf);
    r = (r << w) | 64'(coc);
    r = (r << w) | 64'(res);
    return r;
  endfunction

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic send8(input bit sgn, input logic [7:0] num, input logic [7:0] den,
                       input logic [3:0] tag);
    bit done = 1'b0;
    in8_valid = 1'b1; in8_signed = sgn; in8_num = num; in8_den = den; in8_tag = tag;
    for (int i = 0; i < 100 && !done; i++) begin
      #2;
      if (rst_n && in8_ready) begin
        exp8_q.push_back(22'(ref_pack(8, sgn, 64'(num), 64'(den), 64'(tag))));
        acc8_q.push_back(cyc + 1);
        stl8_q.push_back(stall8);
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) chk("accept_timeout8", 64'(done), 64'd1);
    in8_valid = 1'b0;
  endtask

  task automatic send16(input bit sgn, input logic [15:0] num, input logic [15:0] den,
                        input logic [0:0] tag);
    bit done = 1'b0;
    in16_valid = 1'b1; in16_signed = sgn; in16_num = num; in16_den = den; in16_tag = tag;
    for (int i = 0; i < 100 && !done; i++) begin
      #2;
      if (rst_n && in16_ready) begin
        exp16_q.push_back(35'(ref_pack(16, sgn, 64'(num), 64'(den), 64'(tag))));
        acc16_q.push_back(cyc + 1);
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) chk("accept_timeout16", 64'(done), 64'd1);
    in16_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (exp8_q.size() != 0 || exp16_q.size() != 0); i++)
      @(negedge clk);
    chk("drain", 64'(exp8_q.size() + exp16_q.size()), 64'd0);
  endtask

  // ---------------- monitor: 8-bit instance ----------------
  logic [63:0] snap8;
  bit          hold8 = 1'b0;
  bit          was_rst8 = 1'b0;

  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      exp8_q.delete(); acc8_q.delete(); stl8_q.delete();
      hold8 = 1'b0;
      was_rst8 = 1'b1;
    end else begin
      if (was_rst8) begin
        chk("rst_out_valid8", 64'(out8_valid), 64'd0);
        chk("rst_outputs8", 64'({out8_coc, out8_res, out8_tag, out8_dbz, out8_ovf}), 64'd0);
        chk("rst_in_ready8", 64'(in8_ready), 64'd1);
        was_rst8 = 1'b0;
      end
      chk("in_ready8", 64'(in8_ready), 64'(!(out8_valid && !out8_ready)));
      if (hold8) begin
        chk("hold8", 64'({out8_valid, out8_tag, out8_dbz, out8_ovf, out8_coc, out8_res}), snap8);
        hold8 = 1'b0;
      end
      if (out8_valid && !out8_ready) begin
        snap8 = 64'({out8_valid, out8_tag, out8_dbz, out8_ovf, out8_coc, out8_res});
        hold8 = 1'b1;
        stall8++;
      end
      if (out8_valid && out8_ready) begin
        if (exp8_q.size() == 0) begin
          chk("unexpected_out8", 64'(out8_tag), 64'hdead);
        end else begin
          logic [21:0] e;
          int a, s;
          e = exp8_q.pop_front();
          a = acc8_q.pop_front();
          s = stl8_q.pop_front();
          chk("result8", 64'({out8_tag, out8_dbz, out8_ovf, out8_coc, out8_res}), 64'(e));
          chk("latency8", 64'(cyc + 1 - a), 64'(10 + stall8 - s));
        end
      end
    end
  end

  // ---------------- monitor: 16-bit instance ----------------
  bit was_rst16 = 1'b0;

  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      exp16_q.delete(); acc16_q.delete();
      was_rst16 = 1'b1;
    end else begin
      if (was_rst16) begin
        chk("rst_out_valid16", 64'(out16_valid), 64'd0);
        was_rst16 = 1'b0;
      end
      if (out16_valid && out16_ready) begin
        if (exp16_q.size() == 0) begin
          chk("unexpected_out16", 64'(out16_tag), 64'hdead);
        end else begin
          logic [34:0] e;
          int a;
          e = exp16_q.pop_front();
          a = acc16_q.pop_front();
          chk("result16", 64'({out16_tag, out16_dbz, out16_ovf, out16_coc, out16_res}), 64'(e));
          chk("latency16", 64'(cyc + 1 - a), 64'd18);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases, including divide-by-zero and MIN/-1.
    send8(1'b0, 8'd200, 8'd7,   4'd3);
    send8(1'b1, 8'hF9,  8'h02,  4'd1);
    send8(1'b1, 8'h07,  8'hFE,  4'd2);
    send8(1'b0, 8'd45,  8'h00,  4'd4);
    send8(1'b1, 8'd45,  8'h00,  4'd5);
    send8(1'b1, 8'h80,  8'hFF,  4'd6);
    send8(1'b0, 8'h80,  8'hFF,  4'd7);
    send8(1'b0, 8'hFF,  8'h01,  4'd8);
    send8(1'b1, 8'h80,  8'h03,  4'd9);
    send8(1'b1, 8'h81,  8'h80,  4'd10);
    drain();

    // Back-to-back random stream with a 5-cycle consumer stall mid-stream.
    fork
      begin
        for (int t = 0; t < 16; t++)
          send8(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), 4'(t));
      end
      begin
        repeat (12) @(negedge clk);
        out8_ready = 1'b0;
        repeat (5) @(negedge clk);
        out8_ready = 1'b1;
      end
    join
    drain();

    // Reset while six operations are in flight; only later requests may appear.
    for (int t = 0; t < 6; t++)
      send8(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            8'($urandom_range(1, 255)), 4'(t));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 3; t++)
      send8(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), 4'(12 + t));
    drain();
    repeat (14) @(negedge clk);

    // 16-bit random sweep, biased toward zero divisors and MIN / -1.
    for (int t = 0; t < 1000; t++) begin
      logic [15:0] n, d;
      n = 16'($urandom_range(0, 65535));
      d = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 15) == 0) n = 16'h8000;
      case ($urandom_range(0, 15))
        0: d = 16'h0000;
        1: d = 16'hFFFF;
        2: d = 16'($urandom_range(1, 15));
        default: ;
      endcase
      send16(1'($urandom_range(0, 1)), n, d, 1'(t));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/divisor_segmentado_param.md
# divisor_segmentado_param

Parametrised, fully pipelined integer divider: one quotient bit per stage, one new division accepted per cycle, signed/unsigned mode selected per operation. It succeeds the fixed 8-bit START/DONE pipelined divider. It adds a valid/ready handshake with backpressure, a tag that travels with each operation, and divide-by-zero and overflow flags. It sits between a request producer and a result consumer on the datapath.

## Interface
- SIZE, 8, operand/result width in bits (≥ 2)
- TAG_W, 4, width of the user tag carried alongside each operation (≥ 1)

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready at a rising edge
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned
- in_num  in  SIZE  dividend (numerador)
- in_den  in  SIZE  divisor (denominador)
- in_tag  in  TAG_W  opaque tag, returned unchanged
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready at a rising edge
- out_coc  out  SIZE  quotient
- out_res  out  SIZE  remainder
- out_tag  out  TAG_W  tag of this result
- out_dbz  out  1  divide-by-zero flag for this result
- out_ovf  out  1  signed-overflow flag for this result

## Operation
- The pipeline has SIZE+2 registered stages:
  - S0 captures operands, computes magnitudes (signed mode), and detects den==0 and the signed MIN/−1 case.
  - S1..SIZE each perform one restoring-division step on a (SIZE+1)-bit partial remainder, MSB of quotient first.
  - S(SIZE+1) applies sign correction and flag overrides, and drives all out_* ports directly from registers.
- Each stage carries a valid bit, tag, mode, result signs and flags.
- Global stall: advance = !out_valid || out_ready. When advance=0 every stage holds its contents. in_ready = advance, combinational from out_ready and out_valid. No other combinational input-to-output path exists.
- Bubbles are not compressed. Empty stages still move only when advance=1.
- Unsigned mode: out_coc = num / den, out_res = num mod den.
- Signed mode:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - |out_res| < |den|, and num = coc·den + res holds exactly.
- den == 0, either mode: out_coc = all ones, out_res = in_num, out_dbz=1, out_ovf=0.
- Signed num = −2^(SIZE−1) with den = −1: out_coc = −2^(SIZE−1), out_res = 0, out_ovf=1, out_dbz=0.
- Results leave in acceptance order. out_tag equals the in_tag accepted with that request.

## Timing
- Reset (rst_n=0 at a rising edge):
  - Clears every stage valid bit.
  - Outputs: out_valid=0, out_coc=0, out_res=0, out_tag=0, out_dbz=0, out_ovf=0.
  - in_ready=1 from the cycle after reset, because out_valid=0.
- Reset mid-operation discards all in-flight operations; none of them ever appears at the output.
- Latency: a request accepted at edge k, with advance=1 at every following edge, gives out_valid=1 after edge k+SIZE+1. That is SIZE+2 cycles (10 for SIZE=8).
- Each stall cycle adds exactly one cycle of latency to every in-flight operation.
- Throughput: one result per cycle while out_ready=1.
- The output holds stable (all out_* unchanged) while out_valid && !out_ready.
- Simultaneous accept and consume in the same cycle is legal, and is the steady-state case.
- in_valid=1 while in_ready=0: the request is not taken. The producer must hold it.

## Test plan
- Unsigned, SIZE=8: num=200, den=7, tag=3 → 10 cycles later coc=28, res=4, tag=3, dbz=0, ovf=0.
- Signed, SIZE=8:
  - num=−7 (0xF9), den=2 → coc=0xFD (−3), res=0xFF (−1).
  - num=7, den=−2 → coc=0xFD, res=0x01.
- Corner cases, SIZE=8:
  - num=45, den=0 → coc=0xFF, res=45, dbz=1.
  - Signed num=0x80, den=0xFF → coc=0x80, res=0, ovf=1.
  - Unsigned 0x80/0xFF → coc=0, res=0x80, no flags.
- Backpressure:
  - Stimulus: 16 back-to-back random requests with tags 0..15; out_ready low for 5 cycles mid-stream.
  - Required: in_ready=0 exactly during the stall; out_* stable throughout; all 16 results correct and in tag order; no duplicates.
- Reset mid-stream: rst_n=0 for one edge while 6 operations are in flight → out_valid=0 the next cycle. Only requests accepted after reset produce results.
- Width sweep: SIZE=16, TAG_W=1, 1000 random signed/unsigned operations compared against a reference model → latency exactly 18 cycles and all results match.
